// File: rtl/vga_timing_pkg.sv
// Shared phase enumeration and 640x480@60 default timing for the VGA timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CW       = 16;

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: position counter with wrap and ACTIVE/FRONT/SYNC/BACK phase FSM.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned N_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned N_FP     = DEF_H_FP,
  parameter int unsigned N_SYNC   = DEF_H_SYNC,
  parameter int unsigned N_BP     = DEF_H_BP,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          restart,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_nxt,
  output phase_t        phase_nxt,
  output logic          last
);

  localparam longint unsigned TOT =
    longint'(N_ACTIVE) + longint'(N_FP) + longint'(N_SYNC) + longint'(N_BP);

  if (N_FP == 0 || N_SYNC == 0 || N_BP == 0) begin : g_zero_len
    $error("vga_axis_counter: porch and sync lengths must be non-zero");
  end
  if (TOT > (64'd1 << CW)) begin : g_overflow
    $error("vga_axis_counter: axis total does not fit in CW bits");
  end

  localparam logic [CW-1:0] LAST    = CW'(TOT - 1);
  localparam logic [CW-1:0] B_FRONT = CW'(N_ACTIVE);
  localparam logic [CW-1:0] B_SYNC  = CW'(N_ACTIVE + N_FP);
  localparam logic [CW-1:0] B_BACK  = CW'(N_ACTIVE + N_FP + N_SYNC);

  phase_t        phase;
  logic [CW-1:0] cnt_inc;

  assign last = (cnt == LAST);

  // Phase advances when the incoming count lands on the next phase's first count,
  // so the registered phase always agrees with the registered count.
  always_comb begin
    cnt_inc   = last ? '0 : cnt + CW'(1);
    cnt_nxt   = cnt;
    phase_nxt = phase;
    if (restart) begin
      cnt_nxt   = '0;
      phase_nxt = ACTIVE;
    end else if (step) begin
      cnt_nxt = cnt_inc;
      unique case (phase)
        ACTIVE: if (cnt_inc == B_FRONT) phase_nxt = FRONT;
        FRONT:  if (cnt_inc == B_SYNC)  phase_nxt = SYNC;
        SYNC:   if (cnt_inc == B_BACK)  phase_nxt = BACK;
        BACK:   if (cnt_inc == '0)      phase_nxt = ACTIVE;
        default: phase_nxt = ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= ACTIVE;
    end else begin
      cnt   <= cnt_nxt;
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: H/V axis counters, registered sync/enable/coordinates and event pulses.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic          restart,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_end,
  output logic          frame_start,
  output logic          frame_end
);

  logic [CW-1:0] h_nxt, v_nxt;
  phase_t        h_ph_nxt, v_ph_nxt;
  logic          h_last, v_last;
  logic          h_wrap;
  logic          active_nxt;

  assign h_wrap = pix_en & h_last;

  vga_axis_counter #(
    .N_ACTIVE(H_ACTIVE), .N_FP(H_FP), .N_SYNC(H_SYNC), .N_BP(H_BP), .CW(CW)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .step(pix_en), .restart(restart),
    .cnt(h_cnt), .cnt_nxt(h_nxt), .phase_nxt(h_ph_nxt), .last(h_last)
  );

  vga_axis_counter #(
    .N_ACTIVE(V_ACTIVE), .N_FP(V_FP), .N_SYNC(V_SYNC), .N_BP(V_BP), .CW(CW)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .step(h_wrap), .restart(restart),
    .cnt(v_cnt), .cnt_nxt(v_nxt), .phase_nxt(v_ph_nxt), .last(v_last)
  );

  assign active_nxt = (h_ph_nxt == ACTIVE) && (v_ph_nxt == ACTIVE);

  // Decoding from next-state values keeps these flops in step with h_cnt/v_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync  <= ~HS_POL;
      vsync  <= ~VS_POL;
      active <= 1'b1;
      x      <= '0;
      y      <= '0;
    end else begin
      hsync  <= (h_ph_nxt == SYNC) ? HS_POL : ~HS_POL;
      vsync  <= (v_ph_nxt == SYNC) ? VS_POL : ~VS_POL;
      active <= active_nxt;
      x      <= active_nxt ? h_nxt : '0;
      y      <= active_nxt ? v_nxt : '0;
    end
  end

  assign line_end    = rst_n & pix_en & ~restart & h_last;
  assign frame_end   = line_end & v_last;
  assign frame_start = rst_n & pix_en & (h_cnt == '0) & (v_cnt == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: three configurations checked against a position-level model.
module tb_vga_timing_gen;

  logic clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0, restart = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // cfg0: defaults; cfg1: default H, short frame, VS_POL=1; cfg2: tiny, HS_POL=1
  int HA[3] = '{640, 640, 4};
  int HF[3] = '{16, 16, 1};
  int HS[3] = '{96, 96, 1};
  int HB[3] = '{48, 48, 1};
  int VA[3] = '{480, 8, 2};
  int VF[3] = '{10, 1, 1};
  int VS[3] = '{2, 1, 1};
  int VB[3] = '{33, 1, 1};
  bit HP[3] = '{1'b0, 1'b0, 1'b1};
  bit VP[3] = '{1'b0, 1'b1, 1'b0};

  logic [2:0][15:0] h_cnt_w, v_cnt_w, x_w, y_w;
  logic [2:0] hsync_w, vsync_w, active_w, line_end_w, frame_start_w, frame_end_w;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .restart(restart),
    .h_cnt(h_cnt_w[0]), .v_cnt(v_cnt_w[0]), .x(x_w[0]), .y(y_w[0]),
    .hsync(hsync_w[0]), .vsync(vsync_w[0]), .active(active_w[0]),
    .line_end(line_end_w[0]), .frame_start(frame_start_w[0]), .frame_end(frame_end_w[0])
  );

  vga_timing_gen #(
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1), .VS_POL(1'b1)
  ) u_mid (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .restart(restart),
    .h_cnt(h_cnt_w[1]), .v_cnt(v_cnt_w[1]), .x(x_w[1]), .y(y_w[1]),
    .hsync(hsync_w[1]), .vsync(vsync_w[1]), .active(active_w[1]),
    .line_end(line_end_w[1]), .frame_start(frame_start_w[1]), .frame_end(frame_end_w[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .restart(restart),
    .h_cnt(h_cnt_w[2]), .v_cnt(v_cnt_w[2]), .x(x_w[2]), .y(y_w[2]),
    .hsync(hsync_w[2]), .vsync(vsync_w[2]), .active(active_w[2]),
    .line_end(line_end_w[2]), .frame_start(frame_start_w[2]), .frame_end(frame_end_w[2])
  );

  // Reference model: beam position per configuration
  int mh[3], mv[3];

  function automatic int htot(int c); return HA[c] + HF[c] + HS[c] + HB[c]; endfunction
  function automatic int vtot(int c); return VA[c] + VF[c] + VS[c] + VB[c]; endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int c = 0; c < 3; c++) begin
      if (!rst_n) begin
        mh[c] <= 0; mv[c] <= 0;
      end else if (restart) begin
        mh[c] <= 0; mv[c] <= 0;
      end else if (pix_en) begin
        if (mh[c] == htot(c) - 1) begin
          mh[c] <= 0;
          mv[c] <= (mv[c] == vtot(c) - 1) ? 0 : mv[c] + 1;
        end else begin
          mh[c] <= mh[c] + 1;
        end
      end
    end
  end

  function automatic logic [69:0] obs(int c);
    return {h_cnt_w[c], v_cnt_w[c], x_w[c], y_w[c], hsync_w[c], vsync_w[c],
            active_w[c], line_end_w[c], frame_start_w[c], frame_end_w[c]};
  endfunction

  function automatic logic [69:0] expv(int c);
    int h = mh[c], v = mv[c];
    bit act = (h < HA[c]) && (v < VA[c]);
    bit hs = (h >= HA[c] + HF[c] && h < HA[c] + HF[c] + HS[c]) ? HP[c] : !HP[c];
    bit vs = (v >= VA[c] + VF[c] && v < VA[c] + VF[c] + VS[c]) ? VP[c] : !VP[c];
    bit le = rst_n && pix_en && !restart && (h == htot(c) - 1);
    bit fe = le && (v == vtot(c) - 1);
    bit fs = rst_n && pix_en && h == 0 && v == 0;
    return {16'(h), 16'(v), act ? 16'(h) : 16'd0, act ? 16'(v) : 16'd0,
            hs, vs, act, le, fs, fe};
  endfunction

  function automatic logic [69:0] rexp(int c);
    return {64'd0, !HP[c], !VP[c], 1'b1, 3'b000};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; pix_en = 1'b1; restart = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs(c) !== rexp(c)) begin
        failures++;
        $display("FAIL reset cfg%0d: got %h want %h", c, obs(c), rexp(c));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (frame_start_w !== 3'b111) begin
      failures++;
      $display("FAIL frame_start_after_reset: got %b want 111", frame_start_w);
    end
  endtask

  task automatic test_random(int n, int pe_mod, int rs_mod);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_en  = (pe_mod == 0) ? 1'b1 : (($urandom % pe_mod) != 0);
      restart = (rs_mod == 0) ? 1'b0 : (($urandom % rs_mod) == 0);
      #1;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (obs(c) !== expv(c)) begin
          failures++;
          if (failures <= 20)
            $display("FAIL random cfg%0d (h=%0d v=%0d): got %h want %h",
                     c, mh[c], mv[c], obs(c), expv(c));
        end
      end
    end
    restart = 1'b0;
  endtask

  task automatic test_boundary();
    int k = 0;
    @(negedge clk); restart = 1'b1; pix_en = 1'b1;
    @(negedge clk); restart = 1'b0;
    while (mh[0] != 639 && k < 2000) begin @(negedge clk); k++; end
    #1;
    checks++;
    if (k >= 2000 || active_w[0] !== 1'b1 || x_w[0] !== 16'd639) begin
      failures++;
      $display("FAIL h639: active=%b x=%0d want active=1 x=639", active_w[0], x_w[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (h_cnt_w[0] !== 16'd640 || active_w[0] !== 1'b0 || x_w[0] !== 16'd0) begin
      failures++;
      $display("FAIL h640: h=%0d active=%b x=%0d want h=640 active=0 x=0",
               h_cnt_w[0], active_w[0], x_w[0]);
    end
    k = 0;
    while (!(mh[1] == 799 && mv[1] == 10) && k < 20000) begin @(negedge clk); k++; end
    #1;
    checks++;
    if (k >= 20000 || frame_end_w[1] !== 1'b1 || line_end_w[1] !== 1'b1) begin
      failures++;
      $display("FAIL frame_end: fe=%b le=%b want 1 1", frame_end_w[1], line_end_w[1]);
    end
    @(negedge clk); #1;
    checks++;
    if (h_cnt_w[1] !== 16'd0 || v_cnt_w[1] !== 16'd0 || frame_start_w[1] !== 1'b1) begin
      failures++;
      $display("FAIL frame_wrap: h=%0d v=%0d fs=%b want 0 0 1",
               h_cnt_w[1], v_cnt_w[1], frame_start_w[1]);
    end
  endtask

  task automatic test_restart();
    int tgt[2] = '{700, 799};
    for (int t = 0; t < 2; t++) begin
      int k = 0;
      pix_en = 1'b1;
      while (mh[0] != tgt[t] && k < 2000) begin @(negedge clk); k++; end
      restart = 1'b1;
      #1;
      checks++;
      if (k >= 2000 || line_end_w !== 3'b000 || frame_end_w !== 3'b000) begin
        failures++;
        $display("FAIL restart_pulse@%0d: le=%b fe=%b want 000 000", tgt[t], line_end_w, frame_end_w);
      end
      @(negedge clk);
      restart = 1'b0;
      #1;
      checks++;
      if (h_cnt_w !== '0 || v_cnt_w !== '0 || active_w !== 3'b111) begin
        failures++;
        $display("FAIL restart_pos@%0d: h=%h v=%h active=%b want 0 0 111",
                 tgt[t], h_cnt_w, v_cnt_w, active_w);
      end
    end
  endtask

  task automatic test_periods();
    int last_le = -1, last_fe = -1, n_le = 0, n_fe = 0;
    @(negedge clk); restart = 1'b1; pix_en = 1'b1;
    @(negedge clk); restart = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (i != 0) @(negedge clk);
      pix_en = (i % 2 == 0);
      #1;
      if (line_end_w[0]) begin
        if (last_le >= 0) begin
          checks++;
          if (i - last_le != 1600) begin
            failures++;
            $display("FAIL toggle_line_period: got %0d want 1600", i - last_le);
          end
        end
        last_le = i; n_le++;
      end
    end
    last_le = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); pix_en = 1'b1; #1;
      if (line_end_w[0]) begin
        if (last_le >= 0) begin
          checks++;
          if (i - last_le != 800) begin
            failures++;
            $display("FAIL line_period: got %0d want 800", i - last_le);
          end
        end
        last_le = i; n_le++;
      end
      if (frame_end_w[2]) begin
        if (last_fe >= 0) begin
          checks++;
          if (i - last_fe != 35) begin
            failures++;
            $display("FAIL small_frame_period: got %0d want 35", i - last_fe);
          end
        end
        last_fe = i; n_fe++;
      end
    end
    checks++;
    if (n_le < 4 || n_fe < 10) begin
      failures++;
      $display("FAIL pulse_count: line_end=%0d frame_end=%0d want >=4 >=10", n_le, n_fe);
    end
  endtask

  task automatic test_async_reset();
    pix_en = 1'b1;
    repeat (137) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs(c) !== rexp(c)) begin
        failures++;
        $display("FAIL async_reset cfg%0d: got %h want %h", c, obs(c), rexp(c));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_random(3000, 2, 53);
    test_boundary();
    test_restart();
    test_periods();
    test_async_reset();
    test_random(12000, 8, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
